// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/result bundle between the EX-stage control FSM and
//   the ALU execution unit.
// Ports (master = control side): start, op, a, b, shamt -> unit;
//   res_lo, res_hi, zero, busy, done, div_by_zero -> control.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, shamt,
    input  res_lo, res_hi, zero, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b, shamt,
    output res_lo, res_hi, zero, busy, done, div_by_zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU. Single-cycle ops (ADD/SUB/OR/AND/SLT/SLL) finish
//   in 1 cycle; MULT (shift-add) and DIV (restoring) take WIDTH+1 cycles.
// Ports: clk, rst (async, active-high), bus (slave modport): start is only
//   sampled while busy=0; done pulses one cycle when res_* are written.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave bus
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  localparam logic [SHW:0] CNT_INIT = WIDTH[SHW:0];
  localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  // Shared iteration registers: MUL uses hi = partial product, lo = multiplier
  // (shifting out as product bits shift in); DIV uses hi = remainder,
  // lo = dividend (shifting out as quotient bits shift in).
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  logic [SHW:0]     cnt_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic             zero_q, busy_q, done_q, dbz_q;

  logic [WIDTH-1:0] sc_res_d;
  logic [WIDTH:0]   mul_sum_d;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d;
  logic [WIDTH:0]   div_sh_d, div_diff_d;
  logic [WIDTH-1:0] div_rem_d, div_quo_d;

  // Single-cycle results are computed straight from the request operands and
  // registered at the acceptance edge.
  always_comb begin
    sc_res_d = '0;
    case (bus.op)
      OP_ADD: sc_res_d = bus.a + bus.b;
      OP_SUB: sc_res_d = bus.a - bus.b;
      OP_OR:  sc_res_d = bus.a | bus.b;
      OP_AND: sc_res_d = bus.a & bus.b;
      OP_SLT: sc_res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL: sc_res_d = bus.b << bus.shamt;
      default: sc_res_d = '0;
    endcase
  end

  // One shift-add step: add multiplicand if the current multiplier LSB is set,
  // then shift the whole 2*WIDTH accumulator right (carry enters at the top).
  always_comb begin
    mul_sum_d = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
    {mul_hi_d, mul_lo_d} = {mul_sum_d, acc_lo_q[WIDTH-1:1]};
  end

  // One restoring-division step. The remainder stays below the divisor, so a
  // WIDTH+1 bit trial subtraction suffices; its MSB is the borrow.
  always_comb begin
    div_sh_d   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff_d = div_sh_d - {1'b0, b_q};
    div_rem_d  = div_diff_d[WIDTH] ? div_sh_d[WIDTH-1:0] : div_diff_d[WIDTH-1:0];
    div_quo_d  = {acc_lo_q[WIDTH-2:0], ~div_diff_d[WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
            if (bus.op == OP_MULT) begin
              acc_hi_q <= '0;
              acc_lo_q <= bus.b;
              cnt_q    <= CNT_INIT;
              state_q  <= S_MUL;
            end else if (bus.op == OP_DIV && bus.b != '0) begin
              acc_hi_q <= '0;
              acc_lo_q <= bus.a;
              cnt_q    <= CNT_INIT;
              state_q  <= S_DIV;
            end else if (bus.op == OP_DIV) begin
              // Divide by zero: saturated quotient, dividend as remainder.
              res_lo_q <= '1;
              res_hi_q <= bus.a;
              zero_q   <= 1'b0;
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_FIN;
            end else begin
              res_lo_q <= sc_res_d;
              res_hi_q <= '0;
              zero_q   <= (sc_res_d == '0);
              done_q   <= 1'b1;
              state_q  <= S_FIN;
            end
          end
        end
        S_MUL: begin
          acc_hi_q <= mul_hi_d;
          acc_lo_q <= mul_lo_d;
          cnt_q    <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            res_lo_q <= mul_lo_d;
            res_hi_q <= mul_hi_d;
            zero_q   <= (mul_lo_d == '0);
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end
        S_DIV: begin
          acc_hi_q <= div_rem_d;
          acc_lo_q <= div_quo_d;
          cnt_q    <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            res_lo_q <= div_quo_d;
            res_hi_q <= div_rem_d;
            zero_q   <= (div_quo_d == '0);
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.res_lo      = res_lo_q;
  assign bus.res_hi      = res_hi_q;
  assign bus.zero        = zero_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors for alu_exec_unit with a scoreboard queue
//   of expected results and an independent monitor that checks on every done.
// Ports: none (top-level bench; drives the interface instance directly).
module tb_alu_exec_unit;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  alu_exec_unit_if #(.WIDTH(32), .SHW(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with no outstanding request at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("res_lo", {32'd0, bus.res_lo}, {32'd0, e.lo});
          chk("res_hi", {32'd0, bus.res_hi}, {32'd0, e.hi});
          chk("zero", {63'd0, bus.zero}, {63'd0, (e.lo == 32'd0)});
          chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dbz});
        end
      end
    end
  end

  // Issue one request, optionally poke a stray start mid-run, and measure the
  // start-to-done latency in cycles.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] elo, input logic [31:0] ehi,
                       input logic edbz, input int elat, input bit inject);
    exp_t e;
    int   lat;
    e.lo  = elo;
    e.hi  = ehi;
    e.dbz = edbz;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.shamt = sh;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.shamt = 5'($urandom_range(31, 0));
    lat = 1;
    while (!bus.done && lat < 200) begin
      if (elat > 1 && lat == 5) chk("busy_mid", {63'd0, bus.busy}, 64'd1);
      if (inject && lat == 10) begin
        bus.start = 1'b1;
        bus.op    = OP_ADD;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    chk("latency", 64'(lat), 64'(elat));
    chk("busy_fin", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    chk("busy_idle", {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    bus.shamt = '0;
    repeat (3) @(negedge clk);
    chk("rst_res_lo", {32'd0, bus.res_lo}, 64'd0);
    chk("rst_zero", {63'd0, bus.zero}, 64'd1);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    rst = 1'b0;

    //    op       a             b             sh     lo            hi            dbz  lat inj
    issue(OP_ADD,  32'h00000005, 32'h00000003, 5'd0,  32'h00000008, 32'h0,        1'b0, 1, 0);
    issue(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 32'h0,        1'b0, 1, 0);
    issue(OP_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 32'h0,        1'b0, 1, 0);
    issue(OP_SUB,  32'h00001234, 32'h00001234, 5'd0,  32'h00000000, 32'h0,        1'b0, 1, 0);
    issue(OP_SUB,  32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 32'h0,        1'b0, 1, 0);
    issue(OP_SLL,  32'h0,        32'h00000001, 5'd31, 32'h80000000, 32'h0,        1'b0, 1, 0);
    issue(OP_SLL,  32'h0,        32'h0000ABCD, 5'd0,  32'h0000ABCD, 32'h0,        1'b0, 1, 0);
    issue(OP_OR,   32'h0000F0F0, 32'h00000F00, 5'd0,  32'h0000FFF0, 32'h0,        1'b0, 1, 0);
    issue(OP_AND,  32'h0000F0F0, 32'h00000FF0, 5'd0,  32'h000000F0, 32'h0,        1'b0, 1, 0);
    issue(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 32'h0,        1'b0, 1, 0);
    issue(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 5'd0,  32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1);
    issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, 32'hFFFFFFFE, 1'b0, 33, 0);
    issue(OP_DIV,  32'd100,      32'd7,        5'd0,  32'd14,       32'd2,        1'b0, 33, 0);

    // Asynchronous reset 10 cycles into a MULT: outputs clear without a clock edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'h00000003;
    bus.b     = 32'h00000005;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_res_lo", {32'd0, bus.res_lo}, 64'd0);
    chk("arst_res_hi", {32'd0, bus.res_hi}, 64'd0);
    chk("arst_zero", {63'd0, bus.zero}, 64'd1);
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_done", {63'd0, bus.done}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("arst_still_idle", {63'd0, bus.busy}, 64'd0);

    issue(OP_ADD,  32'h00000010, 32'h00000020, 5'd0,  32'h00000030, 32'h0,        1'b0, 1, 0);
    issue(OP_DIV,  32'h00000055, 32'h00000000, 5'd0,  32'hFFFFFFFF, 32'h00000055, 1'b1, 1, 0);
    issue(OP_ADD,  32'h00000001, 32'h00000002, 5'd0,  32'h00000003, 32'h0,        1'b0, 1, 0);
    issue(OP_DIV,  32'd5,        32'd9,        5'd0,  32'd0,        32'd5,        1'b0, 33, 0);
    issue(OP_DIV,  32'hFFFFFFFF, 32'h00000010, 5'd0,  32'h0FFFFFFF, 32'h0000000F, 1'b0, 33, 0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution end of the ALU-control interface. Consumes the 3-bit ALU operation code from the ALU control decoder and the two register operands, then produces the result.
- Single-cycle ops (ADD, SUB, OR, AND, SLT, SLL/NOP) return in 1 cycle.
- MULT and DIV run iteratively, one bit per cycle.
- Sits in the EX stage. Uses a start/busy/done handshake so the control FSM can stall during MULT/DIV.

Parameters:
- WIDTH, 32, operand and result width in bits (even, >= 4).
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  ALU op code: 000 ADD, 001 SUB, 010 MULT, 011 DIV, 100 OR, 101 AND, 110 SLT, 111 NOP/SLL.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt).
- shamt  in  SHW  shift amount for op 111.
- res_lo  out  WIDTH  main result; LO (product low / quotient) for MULT/DIV.
- res_hi  out  WIDTH  HI: product high / remainder; 0 for single-cycle ops.
- zero  out  1  res_lo == 0.
- busy  out  1  operation in progress; start ignored.
- done  out  1  one-cycle pulse when res_* become valid.
- div_by_zero  out  1  set on DIV with b==0; held until next accepted start.

Behaviour:
- Reset (async, any state): res_lo=0, res_hi=0, zero=1, busy=0, done=0, div_by_zero=0, FSM=IDLE, internal registers cleared. Any operation in flight is discarded; no done is issued.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE, start=1: latch op/a/b/shamt.
  - Single-cycle op, div with b==0, or MULT/DIV with WIDTH-bit zero operand shortcut not used -> FIN.
  - MULT -> MUL.
  - DIV with b!=0 -> DIV.
  - busy=1 from the cycle after acceptance until FIN exits.
- Single-cycle ops: result registered at acceptance edge +1, done pulses in FIN. Latency: done high exactly 1 cycle after the start cycle.
  - ADD/SUB: modulo 2^WIDTH, no overflow flag.
  - SLT: signed two's-complement compare; res_lo = {0..0, a<b}.
  - OR, AND: bitwise.
  - 111: res_lo = b << shamt; shamt=0 is NOP, returning b.
  - res_hi=0 for all of these.
- MUL: unsigned shift-add, 2*WIDTH accumulator, one multiplier bit per cycle, WIDTH cycles via down-counter. Then FIN.
  - done at start+WIDTH+1 cycles (33 for WIDTH=32).
  - res_hi:res_lo = a*b, unsigned.
- DIV: unsigned restoring division, one quotient bit per cycle, WIDTH cycles. Then FIN, same latency as MUL.
  - res_lo = a/b, res_hi = a%b.
- DIV, b==0: no iteration; FIN next cycle. res_lo = all ones, res_hi = a, div_by_zero=1.
- FIN: done=1 for one cycle, busy deasserts at the same edge, then IDLE.
  - start may be accepted in the cycle after FIN (IDLE). Back-to-back throughput: 1 single-cycle op per 2 clocks.
- start while busy=1: ignored, no latching, no error.
- Operand inputs may change freely after acceptance; only latched copies are used.
- res_lo, res_hi, zero, div_by_zero hold their values after done until the next accepted start. At acceptance they are not cleared, only overwritten when the new result is written.
- zero is updated with res_lo every result write.

Test Plan:
- Reset, then ADD a=0x00000005, b=0x00000003 -> done 1 cycle after start, res_lo=0x00000008, res_hi=0, zero=0.
- SLT a=0xFFFFFFFF, b=0x00000001 -> res_lo=1. SUB a=b=0x1234 -> res_lo=0, zero=1. op 111 b=0x1, shamt=31 -> res_lo=0x80000000.
- MULT a=0xFFFFFFFF, b=0x00000002 -> busy for 32 cycles, done on cycle 33, res_hi=0x00000001, res_lo=0xFFFFFFFE. Pulse start with other op mid-run -> ignored, result unchanged.
- DIV a=100, b=7 -> done on cycle 33, res_lo=14, res_hi=2, div_by_zero=0.
- DIV a=0x55, b=0 -> done 1 cycle after start, res_lo=0xFFFFFFFF, res_hi=0x55, div_by_zero=1. Next ADD clears the flag to 0.
- Assert rst 10 cycles into a MULT -> all outputs reset immediately (asynchronous), no done pulse. New ADD accepted after rst release completes normally.
